// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the RISC-V data memory controller:
//   - funct3 encodings for loads and stores
//   - controller state encoding
//   - helpers for byte-enable generation, alignment tests, store lane
//     placement and load extension
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_ACCESS_HI = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  // Stores only know B/H/W; loads additionally accept the unsigned forms.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    return !legal;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // True when the access reaches past byte 3 of its word into the next word.
  function automatic logic spans_two_words(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off == 2'b11;
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte enables over a pair of words {hi, lo}: bits [3:0] belong to the
  // addressed word, bits [7:4] to the following word.
  function automatic logic [7:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] mask;
    case (f3)
      F3_B, F3_BU: mask = 8'h01;
      F3_H, F3_HU: mask = 8'h03;
      F3_W:        mask = 8'h0F;
      default:     mask = 8'h00;
    endcase
    return mask << off;
  endfunction

  // Move right-aligned store data up to its byte lane within the word pair.
  function automatic logic [63:0] align_store(input logic [31:0] wdata, input logic [1:0] off);
    return {32'h0, wdata} << {off, 3'b000};
  endfunction

  // Pick the addressed bytes out of {hi, lo} and sign/zero extend them.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [63:0] pair,
                                              input logic [1:0] off);
    logic [63:0] s;
    s = pair >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_W:    return s[31:0];
      F3_BU:   return {24'h0, s[7:0]};
      F3_HU:   return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// MEM_SIZE x DATA_WIDTH word RAM, byte-enable synchronous write, combinational
// read from the same address.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   be     in  byte enables, one per byte lane
//   addr   in  word index
//   wdata  in  write data (lane aligned)
//   rdata  out read data at addr (combinational)
// -----------------------------------------------------------------------------
module data_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int IDX_W      = $clog2(MEM_SIZE)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // NOTE: RAM arrays carry no reset; clearing them would defeat RAM inference
  // and contents must survive a controller reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Handshaked load/store front end for the word-organised data RAM. One request
// at a time, byte/half/word sizing from funct3, configurable access latency,
// error flag for illegal funct3 and misaligned accesses.
//
// Build option: define MISALIGN_SPLIT_EN to perform misaligned accesses that
// cross a word boundary as two word accesses instead of flagging an error.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  request accepted this cycle if req_valid
//   req_we      in   1 = store, 0 = load
//   req_funct3  in   RISC-V load/store funct3
//   req_addr    in   byte address
//   req_wdata   in   right-aligned store data
//   rsp_valid   out  one-cycle response pulse
//   rsp_rdata   out  extended load data; 0 for stores and errors
//   rsp_err     out  illegal or misaligned access (qualified by rsp_valid)
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(MEM_SIZE);

`ifdef MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic             req_illegal;
  logic             req_misaligned;
  logic             req_spans;
  logic             accept;
  logic             unused_addr_bits;

  assign req_off        = req_addr[1:0];
  assign req_idx        = req_addr[IDX_W+1:2];  // upper bits dropped: index wraps
  assign req_illegal    = is_illegal(req_we, req_funct3);
  assign req_misaligned = is_misaligned(req_funct3, req_off);
  assign req_spans      = spans_two_words(req_funct3, req_off);
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [3:0]       cnt;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_wdata;
  logic [7:0]       r_be;
  logic             r_err;
  logic             r_split;
  logic [31:0]      lo_word;

  assign req_ready = !reset && (state == S_IDLE || state == S_RESP);
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // RAM port
  // ---------------------------------------------------------------------------
  logic                  last_lo;
  logic                  last_hi;
  logic                  in_hi;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The low phase acts one cycle before its counter would reach zero so that
  // the RAM is touched exactly RD_LATENCY cycles after accept. The high phase
  // runs down to zero, adding the turnaround cycle between the two words.
  assign in_hi   = (state == S_ACCESS_HI);
  assign last_lo = (state == S_ACCESS) && (cnt == 4'd1);
  assign last_hi = in_hi && (cnt == 4'd0);

  // Reset gates the write strobe so a store caught mid-access never lands.
  assign mem_we    = !reset && r_we && !r_err && (last_lo || last_hi);
  assign mem_addr  = in_hi ? IDX_W'(r_idx + 1'b1) : r_idx;
  assign mem_be    = in_hi ? r_be[7:4] : r_be[3:0];
  assign mem_wdata = in_hi ? r_wdata[63:32] : r_wdata[31:0];

  data_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all of them update
  // together from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      r_idx     <= '0;
      r_wdata   <= 64'h0;
      r_be      <= 8'h00;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      lo_word   <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= req_off;
            r_idx   <= req_idx;
            r_wdata <= align_store(req_wdata, req_off);
            r_be    <= byte_enables(req_funct3, req_off);
            // Within-word misaligned halves are handled in one phase when
            // splitting is enabled, so only the split-less build rejects them.
            r_err   <= req_illegal || (req_misaligned && !SPLIT_EN);
            r_split <= SPLIT_EN && !req_illegal && req_spans;
            cnt     <= 4'(RD_LATENCY);
            state   <= S_ACCESS;
          end else begin
            state <= S_IDLE;
          end
        end

        S_ACCESS: begin
          if (last_lo) begin
            if (r_split) begin
              lo_word <= mem_rdata;
              cnt     <= 4'(RD_LATENCY);
              state   <= S_ACCESS_HI;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= r_err;
              rsp_rdata <= (r_err || r_we) ? '0 : load_extend(r_f3, {32'h0, mem_rdata}, r_off);
              state     <= S_RESP;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_ACCESS_HI: begin
          if (last_hi) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? '0 : load_extend(r_f3, {mem_rdata, lo_word}, r_off);
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed stimulus with a response scoreboard. Each issued request pushes its
// expected rdata/err and the cycle its response must appear; an independent
// monitor pops and compares on every rsp_valid pulse.
// Supports both builds (MISALIGN_SPLIT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int LAT   = 2;
  localparam int NORM  = 1 + LAT;        // accept -> rsp_valid, single phase
  localparam int SPLIT = 2 + 2 * LAT;    // accept -> rsp_valid, two phases

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_SIZE   (64),
    .RD_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Call right after a rising edge. Returns one cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, output int t_acc);
    int   waited;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    waited     = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    t_acc = cyc;
    if (req_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed low for addr 0x%08h", addr);
    end else if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = t_acc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int lat);
    int t;
    issue(we, f3, addr, wdata, 1'b1, exp_rdata, exp_err, lat, t);
  endtask

  // Wait for all outstanding responses, then realign to just after an edge.
  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses never arrived", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, tr;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1. Reset in the write cycle of a store drops the write.
    req(1'b1, SW, 32'h10, 32'h12345678, 32'h0, 1'b0, NORM);
    req(1'b0, LW, 32'h10, 32'h0, 32'h12345678, 1'b0, NORM);
    drain();
    issue(1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, NORM, tr);
    @(posedge clk);
    #1;                                   // now in cycle accept+LAT
    reset      = 1'b1;
    req_valid  = 1'b1;                    // must be ignored while in reset
    req_we     = 1'b1;
    req_funct3 = SW;
    req_addr   = 32'h10;
    req_wdata  = 32'h0BADF00D;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_rsp_rdata", rsp_rdata, 32'h0);
    check("midreset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req(1'b0, LW, 32'h10, 32'h0, 32'h12345678, 1'b0, NORM);
    drain();

    // 2. Load sizing and extension
    req(1'b1, SW,  32'h0, 32'h80FF7F01, 32'h0, 1'b0, NORM);
    req(1'b0, LB,  32'h0, 32'h0, 32'h00000001, 1'b0, NORM);
    req(1'b0, LB,  32'h1, 32'h0, 32'h0000007F, 1'b0, NORM);
    req(1'b0, LB,  32'h2, 32'h0, 32'hFFFFFFFF, 1'b0, NORM);
    req(1'b0, LBU, 32'h3, 32'h0, 32'h00000080, 1'b0, NORM);
    req(1'b0, LH,  32'h2, 32'h0, 32'hFFFF80FF, 1'b0, NORM);
    req(1'b0, LHU, 32'h2, 32'h0, 32'h000080FF, 1'b0, NORM);
    drain();

    // 3. Partial stores
    req(1'b1, SW, 32'h4, 32'h11223344, 32'h0, 1'b0, NORM);
    req(1'b1, SB, 32'h5, 32'h000000AA, 32'h0, 1'b0, NORM);
    req(1'b0, LW, 32'h4, 32'h0, 32'h1122AA44, 1'b0, NORM);
    req(1'b1, SH, 32'h6, 32'h0000BEEF, 32'h0, 1'b0, NORM);
    req(1'b0, LW, 32'h4, 32'h0, 32'hBEEFAA44, 1'b0, NORM);
    drain();

    // 4. Back-to-back throughput and index wrap
    issue(1'b0, LW, 32'h4, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0, NORM, t1);
    issue(1'b0, LW, 32'h100, 32'h0, 1'b1, 32'h80FF7F01, 1'b0, NORM, t2);
    check("b2b_accept_cycle", 32'(t2), 32'(t1 + 1 + LAT));
    drain();

    // 5. Illegal funct3: error, zero data, no write
    req(1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, NORM);
    req(1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b1, NORM);
    req(1'b1, 3'b100, 32'h4, 32'hFFFFFFFF, 32'h0, 1'b1, NORM);
    req(1'b1, 3'b111, 32'h4, 32'h00000000, 32'h0, 1'b1, NORM);
    req(1'b0, LW, 32'h4, 32'h0, 32'hBEEFAA44, 1'b0, NORM);
    drain();

    // 6. Misaligned accesses
`ifdef MISALIGN_SPLIT_EN
    req(1'b1, SW, 32'h0,  32'h44332211, 32'h0, 1'b0, NORM);
    req(1'b1, SW, 32'h4,  32'h88776655, 32'h0, 1'b0, NORM);
    req(1'b1, SW, 32'hFC, 32'hAABBCCDD, 32'h0, 1'b0, NORM);
    req(1'b0, LW, 32'h2,  32'h0, 32'h66554433, 1'b0, SPLIT);
    req(1'b0, LW, 32'hFE, 32'h0, 32'h2211AABB, 1'b0, SPLIT);
    req(1'b0, LH, 32'h1,  32'h0, 32'h00003322, 1'b0, NORM);
    req(1'b0, LH, 32'h3,  32'h0, 32'h00005544, 1'b0, SPLIT);
    req(1'b1, SW, 32'h6,  32'h0A0B0C0D, 32'h0, 1'b0, SPLIT);
    req(1'b0, LW, 32'h4,  32'h0, 32'h0C0D6655, 1'b0, NORM);
    req(1'b0, LHU, 32'h8, 32'h0, 32'h00000A0B, 1'b0, NORM);
`else
    req(1'b0, LW, 32'h2, 32'h0, 32'h0, 1'b1, NORM);
    req(1'b0, LH, 32'h1, 32'h0, 32'h0, 1'b1, NORM);
    req(1'b0, LHU, 32'h3, 32'h0, 32'h0, 1'b1, NORM);
    req(1'b1, SW, 32'h6, 32'hFFFFFFFF, 32'h0, 1'b1, NORM);
    req(1'b1, SH, 32'h5, 32'h0000FFFF, 32'h0, 1'b1, NORM);
    req(1'b0, LW, 32'h4, 32'h0, 32'hBEEFAA44, 1'b0, NORM);
`endif
    drain();

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
